// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_pkg
// Purpose  : Shared pipeline types for the hazard controller: the FSM state
//            encoding, the register-number width and the NOP instruction.
// Revision : 1.0
// ============================================================================
package hazard_ctrl_pkg;

    localparam int c_REG_W = 3;

    localparam logic [15:0] c_NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_load_use_det.sv
`default_nettype none
// ============================================================================
// Module   : load_use_det
// Purpose  : Flags an ID-stage source read of the register a load in EX has
//            not yet produced.
// Revision : 1.0
// ============================================================================
module load_use_det
    import hazard_ctrl_pkg::*;
(
    input  logic [c_REG_W-1:0] i_id_rs,
    input  logic [c_REG_W-1:0] i_id_rt,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    input  logic [c_REG_W-1:0] i_ex_write_reg,
    input  logic               i_ex_regWrite,
    input  logic               i_ex_memEn,
    input  logic               i_ex_memWrite,
    output logic               o_load_use
);

    logic w_ex_is_load;
    logic w_src_match;

    assign w_ex_is_load = i_ex_regWrite & i_ex_memEn & ~i_ex_memWrite;
    assign w_src_match  = (i_id_uses_rs & (i_id_rs == i_ex_write_reg)) |
                          (i_id_uses_rt & (i_id_rt == i_ex_write_reg));
    assign o_load_use   = w_ex_is_load & w_src_match;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline stall/flush controller with halt drain FSM and a
//            saturating stall statistics counter.
// Revision : 1.0
// ============================================================================
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [c_REG_W-1:0] id_rs,
    input  logic [c_REG_W-1:0] id_rt,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic [c_REG_W-1:0] ex_write_reg,
    input  logic               ex_regWrite,
    input  logic               ex_memEn,
    input  logic               ex_memWrite,
    input  logic               ex_branch_taken,
    input  logic               id_halt,
    input  logic               imem_stall,
    input  logic               dmem_stall,
    output logic               pc_wr_en,
    output logic               if_id_wr_en,
    output logic               id_ex_wr_en,
    output logic               ex_mem_wr_en,
    output logic               mem_wb_wr_en,
    output logic               if_id_flush,
    output logic               id_ex_flush,
    output logic               halted,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int c_DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(DRAIN_CYCLES - 1);

    hz_state_t        r_state;
    hz_state_t        w_state_nxt;
    logic [c_DW-1:0]  r_drain_cnt;
    logic [c_DW-1:0]  w_drain_nxt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_load_use;

    load_use_det u_load_use_det (
        .i_id_rs        (id_rs),
        .i_id_rt        (id_rt),
        .i_id_uses_rs   (id_uses_rs),
        .i_id_uses_rt   (id_uses_rt),
        .i_ex_write_reg (ex_write_reg),
        .i_ex_regWrite  (ex_regWrite),
        .i_ex_memEn     (ex_memEn),
        .i_ex_memWrite  (ex_memWrite),
        .o_load_use     (w_load_use)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_drain_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_nxt;
            if (r_state == ST_RUN && !pc_wr_en && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_drain_nxt  = r_drain_cnt;
        pc_wr_en     = 1'b0;
        if_id_wr_en  = 1'b0;
        id_ex_wr_en  = 1'b0;
        ex_mem_wr_en = 1'b0;
        mem_wb_wr_en = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;

        case (r_state)
            ST_RUN: begin
                // dmem_stall leaves every enable low: a full freeze
                if (!dmem_stall) begin
                    {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 5'b11111;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (w_load_use) begin
                        pc_wr_en    = 1'b0;
                        if_id_wr_en = 1'b0;
                        id_ex_flush = 1'b1;
                    end else if (imem_stall) begin
                        pc_wr_en    = 1'b0;
                        if_id_flush = 1'b1;
                    end
                    // A halt blocked by load-use is retried once the bubble is in
                    if (id_halt && !ex_branch_taken && !w_load_use) begin
                        w_state_nxt = ST_DRAIN;
                        w_drain_nxt = '0;
                    end
                end
            end
            ST_DRAIN: begin
                if (!dmem_stall) begin
                    {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en} = 5'b11111;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        w_state_nxt = ST_RUN;
                        w_drain_nxt = '0;
                    end else begin
                        pc_wr_en    = 1'b0;
                        if_id_flush = 1'b1;
                        if (r_drain_cnt == c_DRAIN_LAST)
                            w_state_nxt = ST_HALTED;
                        else
                            w_drain_nxt = r_drain_cnt + 1'b1;
                    end
                end
            end
            ST_HALTED: ;
            default:   w_state_nxt = ST_RUN;
        endcase

        if (!rst) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_wr_en  = 1'b0;
            ex_mem_wr_en = 1'b0;
            mem_wb_wr_en = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
        end
    end

    assign halted    = rst & (r_state == ST_HALTED);
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed-vector scoreboard bench for hazard_ctrl.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       urs;
        logic       urt;
        logic [2:0] wr;
        logic       rw;
        logic       me;
        logic       mw;
        logic       br;
        logic       hlt;
        logic       im;
        logic       dm;
    } stim_t;

    typedef struct {
        logic [6:0] en;
        logic       h;
        int         cnt;
        int         step;
    } exp_t;

    // {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}
    localparam logic [6:0] E_NORM = 7'b11111_00;
    localparam logic [6:0] E_OFF  = 7'b00000_00;
    localparam logic [6:0] E_BR   = 7'b11111_11;
    localparam logic [6:0] E_LU   = 7'b00111_01;
    localparam logic [6:0] E_IM   = 7'b01111_10;
    localparam logic [6:0] E_DR   = 7'b01111_10;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] id_rs = '0, id_rt = '0, ex_write_reg = '0;
    logic       id_uses_rs = 0, id_uses_rt = 0, ex_regWrite = 0, ex_memEn = 0;
    logic       ex_memWrite = 0, ex_branch_taken = 0, id_halt = 0;
    logic       imem_stall = 0, dmem_stall = 0;
    logic       pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en, mem_wb_wr_en;
    logic       if_id_flush, id_ex_flush, halted;
    logic [3:0] stall_cnt;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   step_no = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.DRAIN_CYCLES(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_write_reg    (ex_write_reg),
        .ex_regWrite     (ex_regWrite),
        .ex_memEn        (ex_memEn),
        .ex_memWrite     (ex_memWrite),
        .ex_branch_taken (ex_branch_taken),
        .id_halt         (id_halt),
        .imem_stall      (imem_stall),
        .dmem_stall      (dmem_stall),
        .pc_wr_en        (pc_wr_en),
        .if_id_wr_en     (if_id_wr_en),
        .id_ex_wr_en     (id_ex_wr_en),
        .ex_mem_wr_en    (ex_mem_wr_en),
        .mem_wb_wr_en    (mem_wb_wr_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .halted          (halted),
        .stall_cnt       (stall_cnt)
    );

    function automatic stim_t ld(input logic [2:0] rs, input logic [2:0] rt,
                                 input logic urs, input logic urt);
        stim_t r;
        r     = '0;
        r.rs  = rs;
        r.rt  = rt;
        r.urs = urs;
        r.urt = urt;
        r.wr  = 3'd3;
        r.rw  = 1'b1;
        r.me  = 1'b1;
        return r;
    endfunction

    // Drives one cycle of stimulus and queues the expected response (cnt<0: unchecked)
    task automatic go(input stim_t s, input logic rst_v, input logic [6:0] e,
                      input logic h, input int c);
        exp_t x;
        @(posedge clk);
        #1;
        rst             = rst_v;
        id_rs           = s.rs;
        id_rt           = s.rt;
        id_uses_rs      = s.urs;
        id_uses_rt      = s.urt;
        ex_write_reg    = s.wr;
        ex_regWrite     = s.rw;
        ex_memEn        = s.me;
        ex_memWrite     = s.mw;
        ex_branch_taken = s.br;
        id_halt         = s.hlt;
        imem_stall      = s.im;
        dmem_stall      = s.dm;
        step_no++;
        x.en   = e;
        x.h    = h;
        x.cnt  = c;
        x.step = step_no;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t       x;
        logic [6:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x   = q.pop_front();
                got = {pc_wr_en, if_id_wr_en, id_ex_wr_en, ex_mem_wr_en,
                       mem_wb_wr_en, if_id_flush, id_ex_flush};
                n_tests++;
                if (got !== x.en || halted !== x.h ||
                    (x.cnt >= 0 && int'(stall_cnt) != x.cnt)) begin
                    n_fail++;
                    $display("FAIL step%0d: en/flush=%b halted=%b stall_cnt=%0d, required en/flush=%b halted=%b stall_cnt=%0d",
                             x.step, got, halted, stall_cnt, x.en, x.h, x.cnt);
                end
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        stim_t idle;
        idle = '0;

        // reset state
        go(idle, 1'b0, E_OFF, 1'b0, 0);
        go(idle, 1'b0, E_OFF, 1'b0, 0);
        go(idle, 1'b1, E_NORM, 1'b0, 0);

        // load r3 in EX, ID reads rt=3: one bubble
        go(ld(3'd0, 3'd3, 1'b0, 1'b1), 1'b1, E_LU, 1'b0, 0);
        s = idle; s.rt = 3'd3; s.urt = 1'b1;
        go(s, 1'b1, E_NORM, 1'b0, 1);
        // rs=3 but unused; store; non-writing instruction: no stall
        go(ld(3'd3, 3'd5, 1'b0, 1'b1), 1'b1, E_NORM, 1'b0, 1);
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.mw = 1'b1;
        go(s, 1'b1, E_NORM, 1'b0, 1);
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.rw = 1'b0;
        go(s, 1'b1, E_NORM, 1'b0, 1);
        go(ld(3'd3, 3'd0, 1'b1, 1'b0), 1'b1, E_LU, 1'b0, 1);
        go(idle, 1'b1, E_NORM, 1'b0, 2);

        // halt with load-use: stall first, accept halt next cycle
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.hlt = 1'b1;
        go(s, 1'b1, E_LU, 1'b0, 2);
        s = idle; s.hlt = 1'b1;
        go(s, 1'b1, E_NORM, 1'b0, 3);
        // drain: 4 advancing cycles with 2 frozen ones interleaved
        s = idle; s.dm = 1'b1;
        go(idle, 1'b1, E_DR, 1'b0, 3);
        go(s,    1'b1, E_OFF, 1'b0, 3);
        go(idle, 1'b1, E_DR, 1'b0, 3);
        go(s,    1'b1, E_OFF, 1'b0, 3);
        go(idle, 1'b1, E_DR, 1'b0, 3);
        go(idle, 1'b1, E_DR, 1'b0, 3);
        go(idle, 1'b1, E_OFF, 1'b1, 3);
        s = idle; s.br = 1'b1; s.im = 1'b1;
        go(s, 1'b1, E_OFF, 1'b1, 3);
        // reset from HALTED
        go(idle, 1'b0, E_OFF, 1'b0, 0);
        go(idle, 1'b1, E_NORM, 1'b0, 0);

        // dmem_stall with branch: 3 frozen cycles then flush
        s = idle; s.dm = 1'b1; s.br = 1'b1;
        go(s, 1'b1, E_OFF, 1'b0, 0);
        go(s, 1'b1, E_OFF, 1'b0, 1);
        go(s, 1'b1, E_OFF, 1'b0, 2);
        s = idle; s.br = 1'b1;
        go(s, 1'b1, E_BR, 1'b0, 3);
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.br = 1'b1;
        go(s, 1'b1, E_BR, 1'b0, 3);
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.dm = 1'b1;
        go(s, 1'b1, E_OFF, 1'b0, 3);
        go(idle, 1'b1, E_NORM, 1'b0, 4);
        s = idle; s.im = 1'b1;
        go(s, 1'b1, E_IM, 1'b0, 4);
        s = ld(3'd0, 3'd3, 1'b0, 1'b1); s.im = 1'b1;
        go(s, 1'b1, E_LU, 1'b0, 5);
        go(idle, 1'b1, E_NORM, 1'b0, 6);

        // branch two cycles into drain returns to RUN
        s = idle; s.hlt = 1'b1;
        go(s, 1'b1, E_NORM, 1'b0, 6);
        go(idle, 1'b1, E_DR, 1'b0, 6);
        go(idle, 1'b1, E_DR, 1'b0, 6);
        s = idle; s.br = 1'b1;
        go(s, 1'b1, E_BR, 1'b0, 6);
        go(idle, 1'b1, E_NORM, 1'b0, 6);

        // reset mid-drain
        s = idle; s.hlt = 1'b1;
        go(s, 1'b1, E_NORM, 1'b0, 6);
        go(idle, 1'b1, E_DR, 1'b0, 6);
        go(idle, 1'b0, E_OFF, 1'b0, 0);
        go(idle, 1'b1, E_NORM, 1'b0, 0);

        // 20 imem stalls saturate a 4-bit counter at 15
        s = idle; s.im = 1'b1;
        for (int i = 0; i < 20; i++)
            go(s, 1'b1, E_IM, 1'b0, (i > 15) ? 15 : i);
        go(idle, 1'b1, E_NORM, 1'b0, 15);
        go(idle, 1'b0, E_OFF, 1'b0, 0);
        go(idle, 1'b1, E_NORM, 1'b0, 0);

        @(negedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_queue: %0d entries left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
